// File: rtl/iic_pkg.sv
// Shared constants and FSM state encoding for the I2C register-file target.
package iic_pkg;

    localparam int IIC_ADDR_W = 7;
    localparam int IIC_BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        SUB,
        ACK_SUB,
        WDATA,
        ACK_WDATA,
        RDATA,
        RACK,
        IGNORE
    } iic_state_e;

endpackage

// File: rtl/iic_slave_regs_if.sv
// Synchronised bus view and edge/condition strobes passed from iic_bus_sync to the target FSM.
interface iic_slave_regs_if;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    modport master (
        output scl_s,
        output sda_s,
        output scl_rise,
        output scl_fall,
        output start,
        output stop
    );

    modport slave (
        input scl_s,
        input sda_s,
        input scl_rise,
        input scl_fall,
        input start,
        input stop
    );

endinterface

// File: rtl/iic_bus_sync.sv
// Two-flop synchroniser plus one history flop per bus line; derives SCL edges and START/STOP.
module iic_bus_sync
    import iic_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    iic_slave_regs_if.master      evt
);

    // Bit 0 and 1 are the synchroniser, bit 2 is the history used for edge detection.
    logic [2:0] sclPipe_q;
    logic [2:0] sdaPipe_q;

    // Reset to the idle-bus level so releasing reset never fabricates a START.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclPipe_q <= 3'b111;
            sdaPipe_q <= 3'b111;
        end else begin
            sclPipe_q <= {sclPipe_q[1:0], scl_i};
            sdaPipe_q <= {sdaPipe_q[1:0], sda_i};
        end
    end

    assign evt.scl_s    = sclPipe_q[1];
    assign evt.sda_s    = sdaPipe_q[1];
    assign evt.scl_rise = sclPipe_q[1] & ~sclPipe_q[2];
    assign evt.scl_fall = ~sclPipe_q[1] & sclPipe_q[2];
    assign evt.start    = sclPipe_q[1] & sclPipe_q[2] & ~sdaPipe_q[1] & sdaPipe_q[2];
    assign evt.stop     = sclPipe_q[1] & sclPipe_q[2] & sdaPipe_q[1] & ~sdaPipe_q[2];

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target with an 8-bit register file addressed by a sub-address byte.
// Define IIC_SLAVE_AUTO_INC_EN to advance the register pointer after every data byte.
module iic_slave_regs
    import iic_pkg::*;
#(
    parameter logic [IIC_ADDR_W-1:0] DEVICE_ID = 7'h21,
    parameter int                    REG_NUM   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_scl,
    inout  wire                           io_sda,
    output logic                          o_wr_en,
    output logic [IIC_BYTE_W-1:0]         o_wr_addr,
    output logic [IIC_BYTE_W-1:0]         o_wr_data,
    output logic                          o_busy,
    output logic [IIC_BYTE_W*REG_NUM-1:0] o_regs
);

    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    iic_slave_regs_if evt ();

    iic_bus_sync u_sync (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .scl_i (i_scl),
        .sda_i (io_sda),
        .evt   (evt)
    );

    iic_state_e            state_q;
    logic [3:0]            bitCnt_q;
    logic [IIC_BYTE_W-1:0] shift_q;
    logic [IIC_BYTE_W-1:0] ptr_q;
    logic                  rw_q;
    logic                  sdaDrv_q;
    logic                  busy_q;
    logic                  wrEn_q;
    logic [IIC_BYTE_W-1:0] wrAddr_q;
    logic [IIC_BYTE_W-1:0] wrData_q;
    logic [IIC_BYTE_W-1:0] regs_q [REG_NUM];

    logic [IIC_BYTE_W-1:0] ptrAfterByte_d;
    logic [IIC_BYTE_W-1:0] rdByte_d;
    logic                  ptrInRange;
    logic                  sampleBit;
    logic                  byteDone;

`ifdef IIC_SLAVE_AUTO_INC_EN
    assign ptrAfterByte_d = ptr_q + 8'd1;
`else
    assign ptrAfterByte_d = ptr_q;
`endif

    assign ptrInRange = ({1'b0, ptr_q} < 9'(REG_NUM));
    assign sampleBit  = evt.scl_rise & evt.scl_s & (bitCnt_q < 4'd8);
    assign byteDone   = evt.scl_fall & (bitCnt_q == 4'd8);

    // Registers beyond the file read back as zero.
    always_comb begin
        rdByte_d = '0;
        if (ptrInRange) begin
            rdByte_d = regs_q[ptr_q[IDX_W-1:0]];
        end
    end

    // Protocol FSM: bits are sampled on SCL rise, SDA drive changes only on SCL fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            rw_q     <= 1'b0;
            sdaDrv_q <= 1'b0;
            busy_q   <= 1'b0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            for (int k = 0; k < REG_NUM; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            wrEn_q <= 1'b0;
            if (evt.stop) begin
                state_q  <= IDLE;
                bitCnt_q <= '0;
                sdaDrv_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (evt.start) begin
                // A repeated START keeps ptr so a sub-address write can be followed by a read.
                state_q  <= ADDR;
                bitCnt_q <= '0;
                sdaDrv_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, IGNORE: begin
                        sdaDrv_q <= 1'b0;
                    end
                    ADDR: begin
                        if (sampleBit) begin
                            shift_q  <= {shift_q[IIC_BYTE_W-2:0], evt.sda_s};
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end else if (byteDone) begin
                            bitCnt_q <= '0;
                            if (shift_q[IIC_BYTE_W-1:1] == DEVICE_ID) begin
                                state_q  <= ACK_ADDR;
                                rw_q     <= shift_q[0];
                                sdaDrv_q <= 1'b1;
                                busy_q   <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (evt.scl_fall) begin
                            if (rw_q) begin
                                state_q  <= RDATA;
                                shift_q  <= rdByte_d;
                                sdaDrv_q <= ~rdByte_d[IIC_BYTE_W-1];
                                bitCnt_q <= 4'd1;
                            end else begin
                                state_q  <= SUB;
                                sdaDrv_q <= 1'b0;
                                bitCnt_q <= '0;
                            end
                        end
                    end
                    SUB: begin
                        if (sampleBit) begin
                            shift_q  <= {shift_q[IIC_BYTE_W-2:0], evt.sda_s};
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end else if (byteDone) begin
                            ptr_q    <= shift_q;
                            state_q  <= ACK_SUB;
                            sdaDrv_q <= 1'b1;
                            bitCnt_q <= '0;
                        end
                    end
                    ACK_SUB, ACK_WDATA: begin
                        if (evt.scl_fall) begin
                            state_q  <= WDATA;
                            sdaDrv_q <= 1'b0;
                            bitCnt_q <= '0;
                        end
                    end
                    WDATA: begin
                        if (sampleBit) begin
                            shift_q  <= {shift_q[IIC_BYTE_W-2:0], evt.sda_s};
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end else if (byteDone) begin
                            // Out-of-range bytes are still acknowledged but leave the file untouched.
                            if (ptrInRange) begin
                                wrEn_q                     <= 1'b1;
                                wrAddr_q                   <= ptr_q;
                                wrData_q                   <= shift_q;
                                regs_q[ptr_q[IDX_W-1:0]]   <= shift_q;
                            end
                            ptr_q    <= ptrAfterByte_d;
                            state_q  <= ACK_WDATA;
                            sdaDrv_q <= 1'b1;
                            bitCnt_q <= '0;
                        end
                    end
                    RDATA: begin
                        if (evt.scl_fall) begin
                            if (bitCnt_q == 4'd8) begin
                                state_q  <= RACK;
                                sdaDrv_q <= 1'b0;
                                bitCnt_q <= '0;
                            end else begin
                                sdaDrv_q <= ~shift_q[IIC_BYTE_W-2];
                                shift_q  <= {shift_q[IIC_BYTE_W-2:0], 1'b0};
                                bitCnt_q <= bitCnt_q + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        // bitCnt marks that the master's ACK has been seen and the next byte is due.
                        if (evt.scl_rise && bitCnt_q == 4'd0) begin
                            if (evt.sda_s) begin
                                state_q <= IGNORE;
                                busy_q  <= 1'b0;
                            end else begin
                                ptr_q    <= ptrAfterByte_d;
                                bitCnt_q <= 4'd1;
                            end
                        end else if (evt.scl_fall && bitCnt_q == 4'd1) begin
                            state_q  <= RDATA;
                            shift_q  <= rdByte_d;
                            sdaDrv_q <= ~rdByte_d[IIC_BYTE_W-1];
                            bitCnt_q <= 4'd1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        sdaDrv_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
        assign o_regs[IIC_BYTE_W*k +: IIC_BYTE_W] = regs_q[k];
    end

    assign io_sda    = sdaDrv_q ? 1'b0 : 1'bz;
    assign o_wr_en   = wrEn_q;
    assign o_wr_addr = wrAddr_q;
    assign o_wr_data = wrData_q;
    assign o_busy    = busy_q;

endmodule

// File: doc/iic_slave_regs.md
IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 7'h21, 7-bit target address (OV7670-compatible).
REQ-002 SHALL have parameter REG_NUM, default 16, register-file depth (1..256).
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_scl  in  1  bus SCL, asynchronous to i_clk.
REQ-006 SHALL have port io_sda  inout  1  bus SDA; driven only as 0, otherwise 1'bz.
REQ-007 SHALL have port o_wr_en  out  1  one-cycle pulse per committed register write.
REQ-008 SHALL have port o_wr_addr  out  8  sub-address of the committed write.
REQ-009 SHALL have port o_wr_data  out  8  data of the committed write.
REQ-010 SHALL have port o_busy  out  1  high while this target is addressed (address match to STOP).
REQ-011 SHALL have port o_regs  out  8*REG_NUM  flat register file, reg[k] at bits [8k+7:8k].

Function
REQ-012 SHALL pass i_scl and io_sda each through a 2-FF synchronizer, then a 1-FF history stage for edge detection; the bus-event-to-action latency SHALL be 3 i_clk.
REQ-013 SHALL detect START as synced SDA 1->0 while synced SCL=1, and STOP as SDA 0->1 while SCL=1; both SHALL be valid in every state.
REQ-014 SHALL sample SDA on the synced SCL rising edge and change its SDA drive only on the synced SCL falling edge.
REQ-015 SHALL use states IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, WDATA, ACK_WDATA, RDATA, RACK, IGNORE.
REQ-016 IDLE: on START -> ADDR, bit counter cleared.
REQ-017 ADDR: shift in 8 bits MSB first; on match with DEVICE_ID -> ACK_ADDR; on mismatch -> IGNORE.
REQ-018 ACK_ADDR: drive SDA=0 for one SCL period; R/W=0 -> SUB; R/W=1 -> load shift register from reg[ptr] -> RDATA.
REQ-019 SUB: shift in 8 bits into ptr -> ACK_SUB (always ACK) -> WDATA.
REQ-020 WDATA: after 8 bits, pulse o_wr_en with o_wr_addr=ptr and o_wr_data=byte, update reg[ptr] -> ACK_WDATA -> WDATA.
REQ-021 If ptr >= REG_NUM, a write SHALL still be ACKed but SHALL NOT pulse o_wr_en or alter o_regs; a read SHALL return 8'h00.
REQ-022 RDATA: drive 8 bits MSB first (drive 0 as 0, drive 1 as release) -> RACK, SDA released.
REQ-023 RACK: sample master bit on rising edge; on 0 (ACK), reload from reg[ptr] -> RDATA; on 1 (NACK) -> IGNORE.
REQ-024 IGNORE: keep SDA released; wait for START (-> ADDR) or STOP (-> IDLE).
REQ-025 A repeated START SHALL go to ADDR and retain ptr (supports the write-sub-address-then-read sequence).
REQ-026 A STOP in any state SHALL go to IDLE and release SDA within 3 i_clk; a byte that is partial at that point SHALL be discarded.
REQ-027 o_busy SHALL rise on entry to ACK_ADDR and fall on STOP, on mismatch, or on entry to IGNORE.

Reset
REQ-028 i_rst SHALL force: state=IDLE, SDA released, ptr=0, all reg[k]=8'h00, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, synchronizer stages=1.
REQ-029 Reset mid-transfer SHALL abort without driving SDA; the target SHALL ignore bus activity until the next START.

Configuration
REQ-030 With IIC_SLAVE_AUTO_INC_EN defined: ptr SHALL increment by 1 (8-bit wrap 255->0) after each written byte and after each read byte that is ACKed.
REQ-031 Without IIC_SLAVE_AUTO_INC_EN: ptr SHALL be constant after SUB; a multi-byte access SHALL target the same register repeatedly.

Structure
REQ-032 The state encoding and the IIC_ADDR_W=7 and IIC_BYTE_W=8 constants SHALL live in the shared package iic_pkg.
REQ-033 The synchronizer and edge detector SHALL form the sub-module iic_bus_sync (outputs scl_s, sda_s, scl_rise, scl_fall, start, stop).

Verification
REQ-034 Write 0x42,0x05,0xA7, then STOP -> three ACKs; one o_wr_en pulse with addr 0x05, data 0xA7; o_regs[47:40]=8'hA7.
REQ-035 0x42,0x05 then repeated START, then 0x43 and master NACK -> SDA carries 0xA7, then SDA released; state returns to IDLE on STOP.
REQ-036 With AUTO_INC: write 0x42,0x0E,0x11,0x22,0x33 -> reg14=0x11, reg15=0x22; 0x33 ACKed and dropped (ptr 16 >= REG_NUM); exactly 2 o_wr_en pulses.
REQ-037 Address 0x44 -> no ACK (SDA high on the 9th clock); o_busy stays 0; no writes.
REQ-038 STOP after 4 data bits of 0x42,0x03 -> no o_wr_en pulse; reg3 unchanged; next transaction at 0x03 succeeds.
REQ-039 i_rst asserted during RDATA with a 0 bit driven -> SDA released on the next i_clk; o_regs all 0x00.
